// File: rtl/flit_read_arb_if.sv
// Bus between the flit read arbiter and its upstream buffers / downstream link.
// The slave view belongs to the arbiter; the master view belongs to whatever drives the buffers.
interface flit_read_arb_if #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);

   logic [NUM_IN-1:0]            in_not_empty;
   logic [NUM_IN*DATA_WIDTH-1:0] in_data;
   logic                         credit_in;
   logic [NUM_IN-1:0]            rd_en;
   logic                         out_valid;
   logic [DATA_WIDTH-1:0]        out_data;
   logic [SRC_W-1:0]             out_src;
   logic                         credit_err;

   modport slave (
      input  in_not_empty, in_data, credit_in,
      output rd_en, out_valid, out_data, out_src, credit_err
   );

   modport master (
      output in_not_empty, in_data, credit_in,
      input  rd_en, out_valid, out_data, out_src, credit_err
   );

endinterface

// File: rtl/flit_read_arb.sv
// Credit-gated round-robin arbiter that locks onto one flit buffer for a whole packet
// and forwards its flits downstream with a one-cycle read latency.
module flit_read_arb #(
   parameter int NUM_IN       = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int CREDIT_WIDTH = 4,
   parameter int MAX_CREDIT   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   flit_read_arb_if.slave  bus
);

   localparam int SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                  state_q, state_d;
   logic [SRC_W-1:0]        g_q, g_d;
   logic [SRC_W-1:0]        p_q, p_d;
   logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
   logic                    credit_err_q, credit_err_d;
   logic                    out_valid_q;
   logic [SRC_W-1:0]        out_src_q;

   logic [NUM_IN-1:0]       rd_c;
   logic                    issue;
   logic                    credit_ok;
   logic                    found;
   logic [SRC_W-1:0]        pick;
   logic [SRC_W-1:0]        cand;
   int                      idx;
   logic [DATA_WIDTH-1:0]   in_word [NUM_IN];
   logic [DATA_WIDTH-1:0]   out_data_c;
   logic                    tail_out;

   // Unpack the flat buffer read bus into one word per buffer
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         in_word[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Data returns a cycle after the strobe, so it is steered by the source latched at issue
   always_comb begin
      out_data_c = '0;
      if (out_valid_q) begin
         out_data_c = in_word[out_src_q];
      end
   end

   assign tail_out  = out_valid_q & out_data_c[DATA_WIDTH-1];
   assign credit_ok = (credit_q != '0);

   // Round-robin search starting just after the last buffer served
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      cand  = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         idx = int'(p_q) + k;
         if (idx >= NUM_IN) begin
            idx = idx - NUM_IN;
         end
         cand = SRC_W'(idx);
         if (!found && bus.in_not_empty[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // A tail only releases the lock when no read overlaps it; an overlapping read is the
   // head of the same buffer's next packet, so the grant is kept
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      p_d     = p_q;
      rd_c    = '0;
      case (state_q)
         IDLE: begin
            if (credit_ok && found) begin
               rd_c[pick] = 1'b1;
               g_d        = pick;
               state_d    = LOCKED;
            end
         end
         LOCKED: begin
            if (credit_ok && bus.in_not_empty[g_q]) begin
               rd_c[g_q] = 1'b1;
            end else if (tail_out) begin
               state_d = IDLE;
               p_d     = out_src_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign issue = |rd_c;

   // Credits: an issue and a returned credit in the same cycle cancel out
   always_comb begin
      credit_d     = credit_q;
      credit_err_d = credit_err_q;
      if (issue && !bus.credit_in) begin
         credit_d = credit_q - 1'b1;
      end else if (!issue && bus.credit_in) begin
         if (credit_q == CREDIT_WIDTH'(MAX_CREDIT)) begin
            credit_err_d = 1'b1;
         end else begin
            credit_d = credit_q + 1'b1;
         end
      end
   end

   // State, credit and output registers; p resets to the last index so the search begins at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         g_q          <= '0;
         p_q          <= SRC_W'(NUM_IN - 1);
         credit_q     <= CREDIT_WIDTH'(MAX_CREDIT);
         credit_err_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_src_q    <= '0;
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         p_q          <= p_d;
         credit_q     <= credit_d;
         credit_err_q <= credit_err_d;
         out_valid_q  <= issue;
         if (issue) begin
            out_src_q <= g_d;
         end
      end
   end

   assign bus.rd_en      = rst_n ? rd_c : '0;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_c;
   assign bus.out_src    = out_src_q;
   assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_flit_read_arb.sv
// Directed bench for flit_read_arb: models four registered-read flit buffers and checks
// grants, packet locking, credit flow, credit error and reset behaviour.
module tb_flit_read_arb;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [31:0] mem   [4][16];
   int          cnt   [4];
   int          rp    [4];
   logic [31:0] rdata [4];
   logic [3:0]  r;
   int          pulses;

   flit_read_arb_if #(.NUM_IN(4), .DATA_WIDTH(32)) bus ();

   flit_read_arb #(
      .NUM_IN(4), .DATA_WIDTH(32), .CREDIT_WIDTH(4), .MAX_CREDIT(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic updateInputs();
      for (int i = 0; i < 4; i++) begin
         bus.in_not_empty[i]      = (cnt[i] > 0);
         bus.in_data[i*32 +: 32]  = rdata[i];
      end
   endtask

   task automatic clearBuffers();
      for (int i = 0; i < 4; i++) begin
         cnt[i]   = 0;
         rp[i]    = 0;
         rdata[i] = '0;
      end
      updateInputs();
   endtask

   task automatic loadFlit(input int b, input logic [31:0] d);
      mem[b][(rp[b] + cnt[b]) % 16] = d;
      cnt[b]++;
      updateInputs();
   endtask

   // One clock: optional credit pulse, sample strobes before the edge, then the buffers pop
   task automatic applyStimulus(input logic credit, output logic [3:0] rd);
      bus.credit_in = credit;
      #1;
      rd = bus.rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (rd[i]) begin
            rdata[i] = mem[i][rp[i]];
            rp[i]    = (rp[i] + 1) % 16;
            cnt[i]--;
         end
      end
      updateInputs();
      bus.credit_in = 1'b0;
      #1;
   endtask

   task automatic doReset();
      rst_n         = 1'b0;
      bus.credit_in = 1'b0;
      clearBuffers();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b1;
      bus.credit_in = 1'b0;
      clearBuffers();
      #1;
      rst_n = 1'b0;

      // Reset values, with buffers 1 and 3 already holding single-flit packets
      loadFlit(1, 32'h8000_0011);
      loadFlit(3, 32'h8000_0033);
      #1;
      checkOutput("rst_rd_en",      32'(bus.rd_en), 32'h0);
      checkOutput("rst_out_valid",  32'(bus.out_valid), 32'h0);
      checkOutput("rst_out_src",    32'(bus.out_src), 32'h0);
      checkOutput("rst_out_data",   bus.out_data, 32'h0);
      checkOutput("rst_credit_err", 32'(bus.credit_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("first_grant", 32'(bus.rd_en), 32'h2);
      applyStimulus(1'b0, r);
      checkOutput("first_valid", 32'(bus.out_valid), 32'h1);
      checkOutput("first_src",   32'(bus.out_src), 32'h1);
      checkOutput("first_data",  bus.out_data, 32'h8000_0011);
      checkOutput("first_tail_no_rd", 32'(bus.rd_en), 32'h0);
      applyStimulus(1'b0, r);
      checkOutput("second_grant", 32'(bus.rd_en), 32'h8);
      applyStimulus(1'b0, r);
      checkOutput("second_src",  32'(bus.out_src), 32'h3);
      checkOutput("second_data", bus.out_data, 32'h8000_0033);

      // Three-flit packet on buffer 0 completes before the single flit on buffer 2
      doReset();
      loadFlit(0, 32'h0000_0A01);
      loadFlit(0, 32'h0000_0A02);
      loadFlit(0, 32'h8000_0A03);
      loadFlit(2, 32'h8000_0C01);
      #1;
      checkOutput("pkt_grant0", 32'(bus.rd_en), 32'h1);
      applyStimulus(1'b0, r);
      checkOutput("pkt_f1", bus.out_data, 32'h0000_0A01);
      checkOutput("pkt_rd1", 32'(bus.rd_en), 32'h1);
      applyStimulus(1'b0, r);
      checkOutput("pkt_f2", bus.out_data, 32'h0000_0A02);
      checkOutput("pkt_rd2", 32'(bus.rd_en), 32'h1);
      applyStimulus(1'b0, r);
      checkOutput("pkt_f3", bus.out_data, 32'h8000_0A03);
      checkOutput("pkt_bubble", 32'(bus.rd_en), 32'h0);
      applyStimulus(1'b0, r);
      checkOutput("pkt_idle_valid", 32'(bus.out_valid), 32'h0);
      checkOutput("pkt_grant2", 32'(bus.rd_en), 32'h4);
      applyStimulus(1'b0, r);
      checkOutput("pkt_b2_src",  32'(bus.out_src), 32'h2);
      checkOutput("pkt_b2_data", bus.out_data, 32'h8000_0C01);

      // Credit exhaustion: eight reads, then one more per returned credit
      doReset();
      for (int k = 0; k < 10; k++) begin
         loadFlit(0, 32'h0000_0100 + 32'(k));
      end
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, r);
         pulses += int'(r[0]);
      end
      checkOutput("credit_pulses", 32'(pulses), 32'd8);
      checkOutput("credit_stall", 32'(bus.rd_en), 32'h0);
      applyStimulus(1'b1, r);
      checkOutput("credit_resume", 32'(bus.rd_en), 32'h1);
      applyStimulus(1'b0, r);
      checkOutput("credit_ninth_data", bus.out_data, 32'h0000_0108);
      checkOutput("credit_stall_again", 32'(bus.rd_en), 32'h0);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, r);
         pulses += int'(r[0]);
      end
      checkOutput("credit_no_extra", 32'(pulses), 32'd0);

      // Back-to-back packets on buffer 1 keep the grant while reads overlap the tail
      doReset();
      loadFlit(1, 32'h0000_0B01);
      loadFlit(1, 32'h8000_0B02);
      loadFlit(1, 32'h0000_0B11);
      loadFlit(1, 32'h8000_0B12);
      loadFlit(2, 32'h8000_0C21);
      #1;
      checkOutput("b2b_grant1", 32'(bus.rd_en), 32'h2);
      applyStimulus(1'b0, r);
      checkOutput("b2b_a_head", bus.out_data, 32'h0000_0B01);
      applyStimulus(1'b0, r);
      checkOutput("b2b_a_tail", bus.out_data, 32'h8000_0B02);
      checkOutput("b2b_overlap_rd", 32'(bus.rd_en), 32'h2);
      applyStimulus(1'b0, r);
      checkOutput("b2b_b_head", bus.out_data, 32'h0000_0B11);
      checkOutput("b2b_b_src", 32'(bus.out_src), 32'h1);
      applyStimulus(1'b0, r);
      checkOutput("b2b_b_tail", bus.out_data, 32'h8000_0B12);
      checkOutput("b2b_release", 32'(bus.rd_en), 32'h0);
      applyStimulus(1'b0, r);
      checkOutput("b2b_grant2", 32'(bus.rd_en), 32'h4);
      applyStimulus(1'b0, r);
      checkOutput("b2b_b2_src",  32'(bus.out_src), 32'h2);
      checkOutput("b2b_b2_data", bus.out_data, 32'h8000_0C21);

      // Credit returned while full is an error and does not grow the counter
      doReset();
      checkOutput("err_clear", 32'(bus.credit_err), 32'h0);
      applyStimulus(1'b1, r);
      checkOutput("err_set", 32'(bus.credit_err), 32'h1);
      for (int k = 0; k < 10; k++) begin
         loadFlit(0, 32'h0000_0200 + 32'(k));
      end
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, r);
         pulses += int'(r[0]);
      end
      checkOutput("err_credit_capped", 32'(pulses), 32'd8);
      checkOutput("err_sticky", 32'(bus.credit_err), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("err_reset", 32'(bus.credit_err), 32'h0);

      // Reset in the middle of a locked packet abandons it and restarts the search at 0
      doReset();
      loadFlit(1, 32'h8000_0D01);
      applyStimulus(1'b0, r);
      checkOutput("mid_b1_data", bus.out_data, 32'h8000_0D01);
      loadFlit(2, 32'h0000_0D21);
      loadFlit(2, 32'h0000_0D22);
      loadFlit(2, 32'h8000_0D23);
      loadFlit(0, 32'h8000_0E01);
      applyStimulus(1'b0, r);
      checkOutput("mid_grant2", 32'(bus.rd_en), 32'h4);
      applyStimulus(1'b0, r);
      checkOutput("mid_locked_valid", 32'(bus.out_valid), 32'h1);
      checkOutput("mid_locked_rd", 32'(bus.rd_en), 32'h4);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_rd_en", 32'(bus.rd_en), 32'h0);
      checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      applyStimulus(1'b0, r);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("mid_restart_grant", 32'(bus.rd_en), 32'h1);
      applyStimulus(1'b0, r);
      checkOutput("mid_restart_src",  32'(bus.out_src), 32'h0);
      checkOutput("mid_restart_data", bus.out_data, 32'h8000_0E01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flit_read_arb.md
FLIT_READ_ARB -- requirements
Module: flit_read_arb

Interface
REQ-001 Parameter: NUM_IN, 4, number of upstream flit buffers arbitrated.
REQ-002 Parameter: DATA_WIDTH, 32, flit width; bit DATA_WIDTH-1 is the tail flag.
REQ-003 Parameter: CREDIT_WIDTH, 4, width of the downstream credit counter.
REQ-004 Parameter: MAX_CREDIT, 8, credits after reset; SHALL be <= 2**CREDIT_WIDTH-1.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_not_empty  input  NUM_IN  per-buffer not-empty flag from each flit buffer.
REQ-008 in_data  input  NUM_IN*DATA_WIDTH  buffer read data, buffer i at bits [i*DATA_WIDTH +: DATA_WIDTH]; valid one cycle after its rd_en.
REQ-009 credit_in  input  1  one-cycle pulse returning one downstream credit.
REQ-010 rd_en  output  NUM_IN  read strobe to buffers; at most one bit high per cycle.
REQ-011 out_valid  output  1  out_data carries a flit this cycle.
REQ-012 out_data  output  DATA_WIDTH  forwarded flit.
REQ-013 out_src  output  log2(NUM_IN)  index of the buffer that supplied out_data.
REQ-014 credit_err  output  1  sticky; credit returned while counter is at MAX_CREDIT.

Function
REQ-015 The FSM SHALL have two states, IDLE and LOCKED, plus a registered grant index g and a last-served index p.
REQ-016 In IDLE with credit>0, the block SHALL select the first i with in_not_empty[i]=1, searching p+1, p+2, ... modulo NUM_IN, assert rd_en[i], set g=i, and enter LOCKED.
REQ-017 In IDLE with credit=0 or no buffer non-empty, rd_en SHALL be 0 and the state SHALL be held.
REQ-018 In LOCKED, rd_en[g] SHALL be asserted combinationally iff in_not_empty[g]=1 and credit>0; no other rd_en bit SHALL assert.
REQ-019 Read latency SHALL be one cycle: out_valid is rd_en issue registered; out_data is in_data slice of the g registered at issue; out_src is that registered g.
REQ-020 When out_valid=1 and out_data[DATA_WIDTH-1]=1 (tail) and no rd_en is asserted that cycle, the FSM SHALL go to IDLE and set p=out_src.
REQ-021 When a tail emerges in the same cycle rd_en[g] is asserted, that read SHALL be the head of the next packet of the same buffer and the FSM SHALL remain LOCKED on g.
REQ-022 IDLE entered on a tail SHALL NOT arbitrate in that same cycle; the earliest new grant is the following cycle (one bubble).
REQ-023 The credit counter SHALL decrement on each rd_en issue, increment on each credit_in, and hold when both occur in the same cycle.
REQ-024 credit_in with counter at MAX_CREDIT and no simultaneous issue SHALL leave the counter at MAX_CREDIT and set credit_err until reset.
REQ-025 A read SHALL never be issued with credit=0 or to a buffer whose in_not_empty is 0.
REQ-026 Single-flit packets (head with tail set) SHALL be handled by REQ-020/REQ-021 unchanged.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, g=0, p=NUM_IN-1, credit=MAX_CREDIT, credit_err=0, out_valid=0, out_src=0, out_data=0; rd_en SHALL be 0 while rst_n is low.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from buffer 0.

Verification
REQ-029 Reset release, buffers 1 and 3 non-empty, credits 8 -> first rd_en=4'b0010 next edge, out_valid with out_src=1 one cycle later.
REQ-030 Buffer 0 holds 3-flit packet, buffer 2 holds 1-flit packet, both pending -> buffer 0 flits on 3 consecutive cycles, one bubble, then buffer 2 flit; no interleaving.
REQ-031 No credit_in, buffer 0 holds 10 flits -> exactly 8 rd_en pulses then rd_en stays 0; one credit_in pulse -> exactly one more read.
REQ-032 Buffer 1 holds two back-to-back 2-flit packets, buffer 2 non-empty -> buffer 1 retains grant across both packets only when read overlaps tail per REQ-021; then buffer 2 is served.
REQ-033 credit_in pulsed with counter at 8 -> counter stays 8, credit_err=1 and remains 1 until rst_n low.
REQ-034 rst_n pulsed low during a LOCKED packet -> rd_en and out_valid drop immediately; after release grant search starts at buffer 0 with credit=8.
